dma_mem_arbiter: RTL
====================

DMA_MEM_ARBITER -- requirements
Module: dma_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of every address port.
REQ-002 Parameter DATA_WIDTH, default 64, width of every data port.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, maximum BUSY cycles waited for mem_ready, range 1..65535.
REQ-004 Clocking SHALL be one clock (sys_clk); reset SHALL be sys_rst_n, asynchronous, active-low.
REQ-005 sys_clk  in  1  sole clock, rising edge.
REQ-006 sys_rst_n  in  1  async active-low reset.
REQ-007 ch_rd_valid  in  4  per-channel read request, bit n = channel n.
REQ-008 ch_rd_addr  in  4*ADDR_WIDTH  read addresses, channel n at [n*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 ch_rd_ready  out  4  read completion strobe per channel.
REQ-010 ch_rd_data  out  DATA_WIDTH  shared read data, valid only while some ch_rd_ready bit is 1.
REQ-011 ch_wr_valid  in  4  per-channel write request.
REQ-012 ch_wr_addr  in  4*ADDR_WIDTH  write addresses, same packing as REQ-008.
REQ-013 ch_wr_data  in  4*DATA_WIDTH  write data, channel n at [n*DATA_WIDTH +: DATA_WIDTH].
REQ-014 ch_wr_ready  out  4  write completion strobe per channel.
REQ-015 ch_err  out  4  one-cycle error pulse per channel (misalign or timeout).
REQ-016 mem_addr  out  ADDR_WIDTH  memory address, registered.
REQ-017 mem_wdata  out  DATA_WIDTH  memory write data, registered.
REQ-018 mem_rdata  in  DATA_WIDTH  memory read data, sampled with mem_ready.
REQ-019 mem_write  out  1  1 = write, 0 = read, registered.
REQ-020 mem_valid  out  1  memory request valid, registered.
REQ-021 mem_ready  in  1  memory accepts/completes the request.
REQ-022 arb_busy  out  1  1 while in BUSY.
REQ-023 grant_id  out  3  current or last slot, slot = {ch[1:0], is_write}.

Function
REQ-024 Eight request slots SHALL exist: slot 2n = channel n read, slot 2n+1 = channel n write.
REQ-025 FSM states SHALL be IDLE and BUSY.
REQ-026 IDLE: if any slot valid, the winner SHALL be the first valid slot at or after rr_ptr, in ascending order mod 8.
REQ-027 IDLE with a winner: the block SHALL register its addr, wdata and write flag, set mem_valid=1 and grant_id=slot, and enter BUSY next cycle.
REQ-028 Misaligned winner (addr[2:0]!=0): the block SHALL issue no memory request, pulse ch_err[ch] next cycle, set rr_ptr=slot+1, and stay in IDLE.
REQ-029 BUSY: mem_valid and mem_addr, mem_wdata and mem_write SHALL stay constant until completion or timeout.
REQ-030 Completion is BUSY && mem_ready; that cycle ch_rd_ready[ch] or ch_wr_ready[ch] SHALL be 1 combinationally, and only for the granted slot.
REQ-031 Read completion: ch_rd_data SHALL equal mem_rdata in that cycle; at all other times ch_rd_data SHALL be 0.
REQ-032 After completion: next cycle mem_valid=0, state IDLE, rr_ptr=(slot+1) mod 8.
REQ-033 Minimum spacing between consecutive mem_valid assertions SHALL be 2 cycles (one IDLE cycle).
REQ-034 Timeout counter: 16-bit, cleared on BUSY entry, incremented each BUSY cycle without mem_ready.
REQ-035 Timeout: when the count reaches TIMEOUT_CYCLES-1 without mem_ready, the block SHALL drop mem_valid, pulse ch_err[ch] for one cycle, give no ready, advance rr_ptr, and return to IDLE.
REQ-036 If mem_ready arrives in the final count cycle, completion SHALL take precedence over timeout.
REQ-037 Requester valid deasserted during BUSY SHALL NOT abort the latched transaction; the ready strobe is still issued.
REQ-038 Requester valid is sampled only in IDLE; new requests during BUSY wait.
REQ-039 Simultaneous read and write valid on one channel: both are arbitrated as independent slots (read slot first when rr_ptr ≤ 2n).
REQ-040 At most one bit across ch_rd_ready, ch_wr_ready and ch_err SHALL be 1 in any cycle.

Reset
REQ-041 Asserting sys_rst_n low SHALL immediately force state=IDLE, rr_ptr=0, timeout count=0, mem_valid=0, mem_write=0, mem_addr=0, mem_wdata=0, grant_id=0, arb_busy=0, and all ready and err bits 0.
REQ-042 Reset mid-BUSY SHALL abandon the transaction with no ready or err pulse; the first grant after release starts from slot 0.

Verification
REQ-043 Single read: ch_rd_valid=4'b0010, addr 0x1000; mem_ready one cycle after mem_valid with mem_rdata=0xDEADBEEF -> mem_addr=0x1000, mem_write=0, ch_rd_ready=4'b0010 with ch_rd_data=0xDEADBEEF.
REQ-044 Round-robin: all 8 slots valid, mem_ready tied 1 -> grant_id sequence 0,1,2,...,7,0 with mem_valid every other cycle.
REQ-045 Timeout: TIMEOUT_CYCLES=4, channel 3 write, mem_ready held 0 -> mem_valid high exactly 4 cycles, then ch_err=4'b1000 for one cycle, no ch_wr_ready.
REQ-046 Misalign: ch_wr_addr ch0=0x1004 -> no mem_valid, ch_err=4'b0001 pulse, next valid slot then granted.
REQ-047 Reset mid-operation: assert sys_rst_n low during BUSY -> mem_valid=0 asynchronously, no strobes; after release with slot 5 valid -> grant_id=5 and rr_ptr later =6.

Source files
------------

// File: rtl/dma_mem_arbiter_if.sv
// Bundle of the four DMA channel ports and the single shared memory port.
// The arbiter connects through the slave modport; requesters and memory connect through master.
interface dma_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [3:0]              ch_rd_valid;
  logic [4*ADDR_WIDTH-1:0] ch_rd_addr;
  logic [3:0]              ch_rd_ready;
  logic [DATA_WIDTH-1:0]   ch_rd_data;
  logic [3:0]              ch_wr_valid;
  logic [4*ADDR_WIDTH-1:0] ch_wr_addr;
  logic [4*DATA_WIDTH-1:0] ch_wr_data;
  logic [3:0]              ch_wr_ready;
  logic [3:0]              ch_err;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_write;
  logic                    mem_valid;
  logic                    mem_ready;
  logic                    arb_busy;
  logic [2:0]              grant_id;

  modport slave (
    input  ch_rd_valid, ch_rd_addr, ch_wr_valid, ch_wr_addr, ch_wr_data,
           mem_rdata, mem_ready,
    output ch_rd_ready, ch_rd_data, ch_wr_ready, ch_err,
           mem_addr, mem_wdata, mem_write, mem_valid, arb_busy, grant_id
  );

  modport master (
    output ch_rd_valid, ch_rd_addr, ch_wr_valid, ch_wr_addr, ch_wr_data,
           mem_rdata, mem_ready,
    input  ch_rd_ready, ch_rd_data, ch_wr_ready, ch_err,
           mem_addr, mem_wdata, mem_write, mem_valid, arb_busy, grant_id
  );
endinterface

// File: rtl/dma_mem_arbiter.sv
// Round-robin arbiter of 8 slots (4 channels x rd/wr) onto one memory port, one
// transaction at a time, with misalignment rejection and a BUSY-cycle timeout.
module dma_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic            sys_clk,
  input logic            sys_rst_n,
  dma_mem_arbiter_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [2:0]            rr_ptr_q, rr_ptr_d;
  logic [2:0]            grant_q, grant_d;
  logic [15:0]           tmo_cnt_q, tmo_cnt_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]            err_q, err_d;

  logic [7:0]            slot_vld;
  logic                  win_vld;
  logic [2:0]            win_slot;
  logic [1:0]            win_ch;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic                  misalign;
  logic                  done;
  logic                  tmo;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      slot_vld[2*n]   = bus.ch_rd_valid[n];
      slot_vld[2*n+1] = bus.ch_wr_valid[n];
    end
  end

  // Scan from the farthest offset down so the slot nearest rr_ptr is written last.
  always_comb begin
    win_vld  = 1'b0;
    win_slot = rr_ptr_q;
    for (int i = 7; i >= 0; i--) begin
      if (slot_vld[3'(rr_ptr_q + 3'(i))]) begin
        win_vld  = 1'b1;
        win_slot = 3'(rr_ptr_q + 3'(i));
      end
    end
  end

  assign win_ch = win_slot[2:1];

  always_comb begin
    if (win_slot[0]) begin
      win_addr  = bus.ch_wr_addr[win_ch*ADDR_WIDTH +: ADDR_WIDTH];
      win_wdata = bus.ch_wr_data[win_ch*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      win_addr  = bus.ch_rd_addr[win_ch*ADDR_WIDTH +: ADDR_WIDTH];
      win_wdata = '0;
    end
  end

  assign misalign = (win_addr[2:0] != 3'b000);
  assign done     = (state_q == BUSY) && bus.mem_ready;
  assign tmo      = (state_q == BUSY) && !bus.mem_ready && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld && !misalign) state_d = BUSY;
      BUSY:    if (done || tmo)          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Completion strobes are combinational from mem_ready so the requester sees them in-cycle.
  always_comb begin
    bus.ch_rd_ready = '0;
    bus.ch_wr_ready = '0;
    bus.ch_rd_data  = '0;
    if (done) begin
      if (mem_write_q) begin
        bus.ch_wr_ready[grant_q[2:1]] = 1'b1;
      end else begin
        bus.ch_rd_ready[grant_q[2:1]] = 1'b1;
        bus.ch_rd_data                = bus.mem_rdata;
      end
    end
  end

  assign bus.arb_busy  = (state_q == BUSY);
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.grant_id  = grant_q;
  assign bus.ch_err    = err_q;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    tmo_cnt_d   = tmo_cnt_q;
    mem_valid_d = mem_valid_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = '0;
    if (state_q == IDLE && win_vld) begin
      if (misalign) begin
        err_d[win_ch] = 1'b1;
        rr_ptr_d      = win_slot + 3'd1;
      end else begin
        mem_valid_d = 1'b1;
        mem_write_d = win_slot[0];
        mem_addr_d  = win_addr;
        mem_wdata_d = win_wdata;
        grant_d     = win_slot;
        tmo_cnt_d   = '0;
      end
    end else if (state_q == BUSY) begin
      if (done) begin
        mem_valid_d = 1'b0;
        rr_ptr_d    = grant_q + 3'd1;
      end else if (tmo) begin
        mem_valid_d          = 1'b0;
        err_d[grant_q[2:1]]  = 1'b1;
        rr_ptr_d             = grant_q + 3'd1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      tmo_cnt_q   <= '0;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      tmo_cnt_q   <= tmo_cnt_d;
      mem_valid_q <= mem_valid_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end
endmodule
